// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and FSM state type for the forward-NTT address generator.
//   N          - polynomial length (fixed 256)
//   LOG_N      - address width
//   BF_LAT_MAX - largest supported butterfly latency
//   state_e    - AGU FSM states
package ntt_pkg;
    localparam int N          = 256;
    localparam int LOG_N      = 8;
    localparam int BF_LAT_MAX = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
endpackage

// File: rtl/agu_wr_delay.sv
// agu_wr_delay: DEPTH-stage shift register that replays {en, addr_a, addr_b} on the write side.
//   clk_i - clock
//   rst_i - synchronous active-high clear of every stage
//   d_i   - read-side {en, addr_a, addr_b}
//   q_o   - the same tuple DEPTH cycles later
module agu_wr_delay #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [16:0] d_i,
    output logic [16:0] q_o
);
    logic [16:0] sr_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end
    assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/agu_ntt.sv
// agu_ntt: Cooley-Tukey forward-NTT address generator (len 128 -> 1, zeta index 1 -> 255).
//   clk_i, rst_i             - clock, synchronous active-high reset
//   start_i                  - start request, honoured only in IDLE
//   busy_o, done_o           - busy in ISSUE/WAIT, one-cycle completion pulse
//   rd_en_o, addr_a_o,
//   addr_b_o, zeta_addr_o    - read side: j, j+len, k
//   wr_en_o, wr_addr_a_o,
//   wr_addr_b_o              - read side replayed BF_LAT cycles later
module agu_ntt #(
    parameter int N      = 256,
    parameter int BF_LAT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] addr_a_o,
    output logic [7:0] addr_b_o,
    output logic [7:0] zeta_addr_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);
    import ntt_pkg::*;
    localparam int CW = $clog2(BF_LAT_MAX + 1);
    state_e           state_q;
    logic [LOG_N-1:0] j_q, start_q, len_q, k_q;
    logic [CW-1:0]    cnt_q;
    logic [LOG_N:0]   j_inc, grp_end, nxt_start;
    logic [16:0]      wr_w;
    // 9-bit arithmetic so the last group's start + 2*len = 256 is representable
    assign j_inc     = {1'b0, j_q} + 9'd1;
    assign grp_end   = {1'b0, start_q} + {1'b0, len_q};
    assign nxt_start = {1'b0, start_q} + {len_q, 1'b0};
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            j_q     <= '0;
            start_q <= '0;
            len_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= ISSUE;
                    len_q   <= 8'd128;
                    start_q <= '0;
                    j_q     <= '0;
                    k_q     <= 8'd1;
                end
                ISSUE: if (j_inc < grp_end) begin
                    j_q <= j_q + 8'd1;
                end else begin
                    k_q <= k_q + 8'd1;
                    if (nxt_start == 9'(N)) begin
                        state_q <= WAIT;
                        cnt_q   <= CW'(BF_LAT);
                    end else begin
                        start_q <= nxt_start[7:0];
                        j_q     <= nxt_start[7:0];
                    end
                end
                // drain the butterfly pipeline before the next layer reads its results
                WAIT: if (cnt_q == CW'(1)) begin
                    if (len_q == 8'd1) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= ISSUE;
                        len_q   <= len_q >> 1;
                        start_q <= '0;
                        j_q     <= '0;
                    end
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                // park addresses at zero so IDLE outputs are clean
                DONE: begin
                    state_q <= IDLE;
                    j_q     <= '0;
                    start_q <= '0;
                    len_q   <= '0;
                    k_q     <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o      = (state_q == ISSUE) || (state_q == WAIT);
    assign done_o      = state_q == DONE;
    assign rd_en_o     = state_q == ISSUE;
    assign addr_a_o    = j_q;
    assign addr_b_o    = j_q + len_q;
    assign zeta_addr_o = k_q;
    agu_wr_delay #(.DEPTH(BF_LAT)) u_wr_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({rd_en_o, addr_a_o, addr_b_o}),
        .q_o   (wr_w)
    );
    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = wr_w;
endmodule

// File: tb/tb_agu_ntt.sv
// tb_agu_ntt: directed self-checking bench for agu_ntt (BF_LAT 4 main, 1 and 16 write-alignment).
module tb_agu_ntt;
    typedef struct {
        int idx;
        int a;
        int b;
        int k;
        int cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic       busy [3], done [3], rd [3], we [3];
    logic [7:0] aa [3], bb [3], zz [3], wa [3], wb [3];

    int checks = 0;
    int errors = 0;
    int ref_a [1024], ref_b [1024], ref_k [1024];
    int cap_a [1024], cap_b [1024], cap_k [1024], cap_cyc [1024];
    int cap_n, done_cyc;
    int dcnt [3] = '{0, 0, 0};
    int lat [3] = '{4, 1, 16};
    logic [16:0] hist [3][17];
    logic rst_s = 1'b0;
    logic armed = 1'b0;
    vec_t tv [7];
    int rj;

    always #5 clk = ~clk;

    agu_ntt #(.BF_LAT(4)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy[0]), .done_o(done[0]),
        .rd_en_o(rd[0]), .addr_a_o(aa[0]), .addr_b_o(bb[0]), .zeta_addr_o(zz[0]),
        .wr_en_o(we[0]), .wr_addr_a_o(wa[0]), .wr_addr_b_o(wb[0]));
    agu_ntt #(.BF_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy[1]), .done_o(done[1]),
        .rd_en_o(rd[1]), .addr_a_o(aa[1]), .addr_b_o(bb[1]), .zeta_addr_o(zz[1]),
        .wr_en_o(we[1]), .wr_addr_a_o(wa[1]), .wr_addr_b_o(wb[1]));
    agu_ntt #(.BF_LAT(16)) u_lat16 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy[2]), .done_o(done[2]),
        .rd_en_o(rd[2]), .addr_a_o(aa[2]), .addr_b_o(bb[2]), .zeta_addr_o(zz[2]),
        .wr_en_o(we[2]), .wr_addr_a_o(wa[2]), .wr_addr_b_o(wb[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rst_s <= rst_i;

    // write stream must equal the read stream BF_LAT cycles earlier; a reset empties the line
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_s) for (int i = 0; i < 17; i++) hist[d][i] = '0;
            if (armed) chk($sformatf("wr_align_lat%0d", lat[d]), {we[d], wa[d], wb[d]}, hist[d][lat[d]-1]);
            for (int i = 16; i > 0; i--) hist[d][i] = hist[d][i-1];
            hist[d][0] = {rd[d], aa[d], bb[d]};
            if (done[d]) dcnt[d]++;
        end
        if (rst_s) armed = 1'b1;
    end

    task automatic run(input int busy_at, input int rst_at);
        cap_n = 0;
        done_cyc = -1;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (rst_i) begin
                rst_i = 1'b0;
                break;
            end
            start_i = 1'b0;
            if (rd[0]) begin
                if (cap_n < 1024) begin
                    cap_a[cap_n] = aa[0];
                    cap_b[cap_n] = bb[0];
                    cap_k[cap_n] = zz[0];
                    cap_cyc[cap_n] = c;
                end
                if (cap_n == busy_at) start_i = 1'b1;
                if (cap_n == rst_at) rst_i = 1'b1;
                cap_n++;
            end
            if (done[0]) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic check_run(input string nm);
        chk({nm, "_issue_count"}, cap_n, 1024);
        for (int i = 0; i < 1024; i++)
            chk($sformatf("%s_issue%0d", nm, i),
                {16'(cap_cyc[i]), 8'(cap_a[i]), 8'(cap_b[i]), 8'(cap_k[i])},
                {16'(1 + i + (i / 128) * 4), 8'(ref_a[i]), 8'(ref_b[i]), 8'(ref_k[i])});
        for (int v = 0; v < 7; v++)
            chk($sformatf("%s_vec%0d", nm, tv[v].idx),
                {16'(cap_cyc[tv[v].idx]), 8'(cap_a[tv[v].idx]), 8'(cap_b[tv[v].idx]), 8'(cap_k[tv[v].idx])},
                {16'(tv[v].cyc), 8'(tv[v].a), 8'(tv[v].b), 8'(tv[v].k)});
        chk({nm, "_done_cycle"}, done_cyc, 1057);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{0, 0, 128, 1, 1};
        tv[1] = '{127, 127, 255, 1, 128};
        tv[2] = '{128, 0, 64, 2, 133};
        tv[3] = '{192, 128, 192, 3, 197};
        tv[4] = '{256, 0, 32, 4, 265};
        tv[5] = '{1022, 252, 253, 254, 1051};
        tv[6] = '{1023, 254, 255, 255, 1052};
        begin
            int n, k;
            n = 0;
            k = 0;
            for (int len = 128; len > 0; len = len >> 1)
                for (int st = 0; st < 256; st = rj + len) begin
                    k++;
                    for (rj = st; rj < st + len; rj++) begin
                        ref_a[n] = rj;
                        ref_b[n] = rj + len;
                        ref_k[n] = k;
                        n++;
                    end
                end
        end
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", {busy[0], done[0], rd[0], aa[0], bb[0], zz[0], we[0], wa[0], wb[0]}, 0);
        end
        run(-1, -1);
        check_run("full");
        run(-1, -1);
        check_run("back_to_back");
        @(negedge clk);
        chk("idle_after_done", {busy[0], done[0], we[0]}, 0);
        run(300, -1);
        check_run("busy_start");
        run(-1, 500);
        chk("mid_reset_issues", cap_n, 501);
        repeat (20) begin
            @(negedge clk);
            chk("mid_reset_quiet", {we[0], busy[0], rd[0], done[0]}, 0);
        end
        run(-1, -1);
        check_run("after_reset");
        repeat (200) @(negedge clk);
        chk("lat1_completed", dcnt[1] > 0, 1);
        chk("lat16_completed", dcnt[2] > 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
